spu_dst_tag_pipe: RTL and testbench

- Producer side of the dual-issue SPU forwarding interface.
- Holds destination-register tags for every instruction in flight in the even and odd execution pipes, one 7-stage shift register per pipe, and advances them each clock.
- Drives the per-stage dst/wr/latency tags that the forwarding logic compares against source registers.
- Generates register-file write strobes at stage 7, supports partial flush of younger stages on branch mispredict, and flags illegal-latency and same-cycle write collisions.

---
 rtl/spu_dst_tag_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_spu_dst_tag_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_dst_tag_pipe.sv
// spu_dst_tag_pipe
// Producer side of the dual-issue SPU forwarding interface. Tracks the
// destination tag of every in-flight instruction in the even and odd
// execution pipes (one NSTG-deep shift register per pipe), exposes the
// per-stage tags to the forwarding comparators, and generates the
// register-file write strobes when an entry leaves the last stage.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   issue_{even,odd}_valid/dst/wr/lat  instruction issued this cycle per pipe
//   flush, flush_depth            kill the incoming issue and the youngest
//                                 flush_depth in-flight stages
//   reg_dst_*, reg_wr_*, latency_*  per-stage tags, stage 1 in the LSB slice
//   fw_rdy_*                      stage result can be forwarded
//   rf_we_*, rf_waddr_*           register-file write ports (registered)
//   inflight_*                    number of live writers per pipe
//   lat_err, waw_err              sticky error flags, cleared only by reset
module spu_dst_tag_pipe #(
    parameter int NSTG = 7,
    parameter int REGW = 7,
    parameter int LATW = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_even_valid,
    input  logic [REGW-1:0]        issue_even_dst,
    input  logic                   issue_even_wr,
    input  logic [LATW-1:0]        issue_even_lat,
    input  logic                   issue_odd_valid,
    input  logic [REGW-1:0]        issue_odd_dst,
    input  logic                   issue_odd_wr,
    input  logic [LATW-1:0]        issue_odd_lat,
    input  logic                   flush,
    input  logic [2:0]             flush_depth,
    output logic [NSTG*REGW-1:0]   reg_dst_even,
    output logic [NSTG-1:0]        reg_wr_even,
    output logic [NSTG*LATW-1:0]   latency_even,
    output logic [NSTG-1:0]        fw_rdy_even,
    output logic [NSTG*REGW-1:0]   reg_dst_odd,
    output logic [NSTG-1:0]        reg_wr_odd,
    output logic [NSTG*LATW-1:0]   latency_odd,
    output logic [NSTG-1:0]        fw_rdy_odd,
    output logic                   rf_we_even,
    output logic [REGW-1:0]        rf_waddr_even,
    output logic                   rf_we_odd,
    output logic [REGW-1:0]        rf_waddr_odd,
    output logic [2:0]             inflight_even,
    output logic [2:0]             inflight_odd,
    output logic                   lat_err,
    output logic                   waw_err
);

    localparam int NP   = 2;   // pipe 0 = even, pipe 1 = odd
    localparam int CNTW = 3;

    // Legal result latency window for a writing instruction.
    function automatic logic lat_legal(input logic [LATW-1:0] lat);
        return (lat >= LATW'(2)) && (lat <= LATW'(7));
    endfunction

    // Number of set bits in a stage write-valid vector.
    function automatic logic [CNTW-1:0] popcnt(input logic [NSTG-1:0] v);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < NSTG; i++) begin
            c = c + CNTW'(v[i]);
        end
        return c;
    endfunction

    logic             iss_valid_s [NP];
    logic [REGW-1:0]  iss_dst_s   [NP];
    logic             iss_wr_s    [NP];
    logic [LATW-1:0]  iss_lat_s   [NP];
    logic [NSTG-1:0]  kill_s;
    logic             lat_bad_s;

    logic [REGW-1:0]  dst_q [NP][NSTG];
    logic [REGW-1:0]  dst_d [NP][NSTG];
    logic [LATW-1:0]  lat_q [NP][NSTG];
    logic [LATW-1:0]  lat_d [NP][NSTG];
    logic [NSTG-1:0]  wr_q  [NP];
    logic [NSTG-1:0]  wr_d  [NP];
    logic             rf_we_q    [NP];
    logic             rf_we_d    [NP];
    logic [REGW-1:0]  rf_waddr_q [NP];
    logic [REGW-1:0]  rf_waddr_d [NP];
    logic [CNTW-1:0]  inflight_q [NP];
    logic [CNTW-1:0]  inflight_d [NP];
    logic             lat_err_q, lat_err_d;
    logic             waw_err_q, waw_err_d;

    // Gather the two issue ports into pipe-indexed arrays.
    always_comb begin
        iss_valid_s[0] = issue_even_valid;
        iss_dst_s[0]   = issue_even_dst;
        iss_wr_s[0]    = issue_even_wr;
        iss_lat_s[0]   = issue_even_lat;
        iss_valid_s[1] = issue_odd_valid;
        iss_dst_s[1]   = issue_odd_dst;
        iss_wr_s[1]    = issue_odd_wr;
        iss_lat_s[1]   = issue_odd_lat;
    end

    // Kill mask over post-shift stages: stage k+1 dies when 2 <= k+1 <= depth+1.
    // Stage 1 is the incoming issue, handled separately; the upper bound
    // naturally clamps at the last stage.
    always_comb begin
        kill_s = '0;
        for (int k = 1; k < NSTG; k++) begin
            kill_s[k] = flush && (int'(flush_depth) >= k);
        end
    end

    // Next-state: shift both pipes, load the issue, apply flush, build strobes.
    always_comb begin
        lat_bad_s = 1'b0;
        for (int p = 0; p < NP; p++) begin
            dst_d[p][0] = iss_dst_s[p];
            lat_d[p][0] = iss_lat_s[p];
            wr_d[p]     = '0;
            // An illegal latency never becomes a writer.
            wr_d[p][0]  = iss_valid_s[p] & iss_wr_s[p] & lat_legal(iss_lat_s[p]) & ~flush;
            lat_bad_s   = lat_bad_s | (iss_valid_s[p] & iss_wr_s[p] & ~lat_legal(iss_lat_s[p]));
            for (int k = 1; k < NSTG; k++) begin
                dst_d[p][k] = dst_q[p][k-1];
                lat_d[p][k] = lat_q[p][k-1];
                wr_d[p][k]  = wr_q[p][k-1] & ~kill_s[k];
            end
            // The retiring entry writes regardless of flush.
            rf_we_d[p]    = wr_q[p][NSTG-1];
            rf_waddr_d[p] = dst_q[p][NSTG-1];
            inflight_d[p] = popcnt(wr_d[p]);
        end
        lat_err_d = lat_err_q | lat_bad_s;
        waw_err_d = waw_err_q | (wr_q[0][NSTG-1] & wr_q[1][NSTG-1] &
                                 (dst_q[0][NSTG-1] == dst_q[1][NSTG-1]));
    end

    // State registers; reset drops every in-flight tag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < NSTG; k++) begin
                    dst_q[p][k] <= '0;
                    lat_q[p][k] <= '0;
                end
                wr_q[p]       <= '0;
                rf_we_q[p]    <= 1'b0;
                rf_waddr_q[p] <= '0;
                inflight_q[p] <= '0;
            end
            lat_err_q <= 1'b0;
            waw_err_q <= 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < NSTG; k++) begin
                    dst_q[p][k] <= dst_d[p][k];
                    lat_q[p][k] <= lat_d[p][k];
                end
                wr_q[p]       <= wr_d[p];
                rf_we_q[p]    <= rf_we_d[p];
                rf_waddr_q[p] <= rf_waddr_d[p];
                inflight_q[p] <= inflight_d[p];
            end
            lat_err_q <= lat_err_d;
            waw_err_q <= waw_err_d;
        end
    end

    // Flatten stage registers onto the outputs and derive forwarding readiness.
    always_comb begin
        reg_dst_even = '0;
        latency_even = '0;
        fw_rdy_even  = '0;
        reg_dst_odd  = '0;
        latency_odd  = '0;
        fw_rdy_odd   = '0;
        for (int k = 0; k < NSTG; k++) begin
            reg_dst_even[k*REGW +: REGW] = dst_q[0][k];
            latency_even[k*LATW +: LATW] = lat_q[0][k];
            reg_dst_odd[k*REGW +: REGW]  = dst_q[1][k];
            latency_odd[k*LATW +: LATW]  = lat_q[1][k];
            // Stage number is k+1; the result exists once stage >= latency.
            fw_rdy_even[k] = wr_q[0][k] & (LATW'(k + 1) >= lat_q[0][k]);
            fw_rdy_odd[k]  = wr_q[1][k] & (LATW'(k + 1) >= lat_q[1][k]);
        end
    end

    assign reg_wr_even   = wr_q[0];
    assign reg_wr_odd    = wr_q[1];
    assign rf_we_even    = rf_we_q[0];
    assign rf_waddr_even = rf_waddr_q[0];
    assign rf_we_odd     = rf_we_q[1];
    assign rf_waddr_odd  = rf_waddr_q[1];
    assign inflight_even = inflight_q[0];
    assign inflight_odd  = inflight_q[1];
    assign lat_err       = lat_err_q;
    assign waw_err       = waw_err_q;

endmodule

// File: tb/tb_spu_dst_tag_pipe.sv
module tb_spu_dst_tag_pipe;
    localparam int NSTG = 7;
    localparam int REGW = 7;
    localparam int LATW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic issue_even_valid, issue_even_wr, issue_odd_valid, issue_odd_wr, flush;
    logic [REGW-1:0] issue_even_dst, issue_odd_dst;
    logic [LATW-1:0] issue_even_lat, issue_odd_lat;
    logic [2:0] flush_depth;
    logic [NSTG*REGW-1:0] reg_dst_even, reg_dst_odd;
    logic [NSTG-1:0] reg_wr_even, reg_wr_odd, fw_rdy_even, fw_rdy_odd;
    logic [NSTG*LATW-1:0] latency_even, latency_odd;
    logic rf_we_even, rf_we_odd, lat_err, waw_err;
    logic [REGW-1:0] rf_waddr_even, rf_waddr_odd;
    logic [2:0] inflight_even, inflight_odd;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic            odd;
        logic            valid;
        logic [REGW-1:0] dst;
        logic            wr;
        logic [LATW-1:0] lat;
        logic            exp_wr;
        logic            exp_lat_err;
    } vec_t;
    vec_t vt [7];

    typedef struct {
        int              due;
        logic [REGW-1:0] addr;
    } wr_t;
    wr_t sb_e [$];
    wr_t sb_o [$];

    spu_dst_tag_pipe #(.NSTG(NSTG), .REGW(REGW), .LATW(LATW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_even_valid(issue_even_valid), .issue_even_dst(issue_even_dst),
        .issue_even_wr(issue_even_wr), .issue_even_lat(issue_even_lat),
        .issue_odd_valid(issue_odd_valid), .issue_odd_dst(issue_odd_dst),
        .issue_odd_wr(issue_odd_wr), .issue_odd_lat(issue_odd_lat),
        .flush(flush), .flush_depth(flush_depth),
        .reg_dst_even(reg_dst_even), .reg_wr_even(reg_wr_even),
        .latency_even(latency_even), .fw_rdy_even(fw_rdy_even),
        .reg_dst_odd(reg_dst_odd), .reg_wr_odd(reg_wr_odd),
        .latency_odd(latency_odd), .fw_rdy_odd(fw_rdy_odd),
        .rf_we_even(rf_we_even), .rf_waddr_even(rf_waddr_even),
        .rf_we_odd(rf_we_odd), .rf_waddr_odd(rf_waddr_odd),
        .inflight_even(inflight_even), .inflight_odd(inflight_odd),
        .lat_err(lat_err), .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    // Edge counter used to time scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        issue_even_valid = 1'b0; issue_even_dst = '0; issue_even_wr = 1'b0; issue_even_lat = '0;
        issue_odd_valid  = 1'b0; issue_odd_dst  = '0; issue_odd_wr  = 1'b0; issue_odd_lat  = '0;
        flush = 1'b0; flush_depth = 3'd0;
    endtask

    task automatic drive(input logic odd, input logic v, input logic [REGW-1:0] d,
                         input logic w, input logic [LATW-1:0] l);
        if (odd) begin
            issue_odd_valid = v; issue_odd_dst = d; issue_odd_wr = w; issue_odd_lat = l;
        end else begin
            issue_even_valid = v; issue_even_dst = d; issue_even_wr = w; issue_even_lat = l;
        end
    endtask

    task automatic push(input logic odd, input logic [REGW-1:0] a);
        wr_t e;
        e.due  = cyc + 8;
        e.addr = a;
        if (odd) sb_o.push_back(e);
        else     sb_e.push_back(e);
    endtask

    // Write-port monitor: each cycle the strobe must match the scoreboard head.
    always @(negedge clk) begin
        if (sb_e.size() > 0 && sb_e[0].due == cyc) begin
            chk("rf_we_even", 64'(rf_we_even), 64'd1);
            chk("rf_waddr_even", 64'(rf_waddr_even), 64'(sb_e[0].addr));
            void'(sb_e.pop_front());
        end else begin
            chk("rf_we_even_quiet", 64'(rf_we_even), 64'd0);
        end
        if (sb_o.size() > 0 && sb_o[0].due == cyc) begin
            chk("rf_we_odd", 64'(rf_we_odd), 64'd1);
            chk("rf_waddr_odd", 64'(rf_waddr_odd), 64'(sb_o[0].addr));
            void'(sb_o.pop_front());
        end else begin
            chk("rf_we_odd_quiet", 64'(rf_we_odd), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NSTG*REGW-1:0] dsts;
        logic [NSTG*LATW-1:0] lats;
        logic [NSTG-1:0]      wrs, rdys;
        logic [2:0]           inf, inf_other;

        vt[0] = '{1'b0, 1'b1, 7'd5,   1'b1, 5'd2, 1'b1, 1'b0};
        vt[1] = '{1'b1, 1'b1, 7'h7F,  1'b1, 5'd6, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 7'd3,   1'b0, 5'd4, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 7'd10,  1'b1, 5'd7, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 7'd9,   1'b1, 5'd3, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 7'd20,  1'b1, 5'd9, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 7'd1,   1'b1, 5'd1, 1'b0, 1'b1};

        // Reset held with live issues on both pipes.
        idle();
        drive(1'b0, 1'b1, 7'd5, 1'b1, 5'd2);
        drive(1'b1, 1'b1, 7'd9, 1'b1, 5'd3);
        repeat (3) @(negedge clk);
        chk("reset_dst", 64'(reg_dst_even | reg_dst_odd), 64'd0);
        chk("reset_wr_lat", 64'({reg_wr_even, reg_wr_odd, latency_even}), 64'd0);
        chk("reset_lat_odd_rdy", 64'({latency_odd, fw_rdy_even, fw_rdy_odd}), 64'd0);
        chk("reset_misc", 64'({rf_we_even, rf_we_odd, rf_waddr_even, rf_waddr_odd,
                                inflight_even, inflight_odd, lat_err, waw_err}), 64'd0);
        idle();
        rst_n = 1'b1;

        // Single-instruction vectors walked through all stages.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vt[i].odd, vt[i].valid, vt[i].dst, vt[i].wr, vt[i].lat);
            if (vt[i].exp_wr) push(vt[i].odd, vt[i].dst);
            for (int s = 1; s <= NSTG; s++) begin
                @(negedge clk);
                idle();
                if (vt[i].odd) begin
                    dsts = reg_dst_odd; lats = latency_odd; wrs = reg_wr_odd; rdys = fw_rdy_odd;
                    inf = inflight_odd; inf_other = inflight_even;
                end else begin
                    dsts = reg_dst_even; lats = latency_even; wrs = reg_wr_even; rdys = fw_rdy_even;
                    inf = inflight_even; inf_other = inflight_odd;
                end
                chk("stage_dst", 64'(dsts[(s-1)*REGW +: REGW]), 64'(vt[i].dst));
                chk("stage_lat", 64'(lats[(s-1)*LATW +: LATW]), 64'(vt[i].lat));
                chk("stage_wr", 64'(wrs), vt[i].exp_wr ? (64'd1 << (s-1)) : 64'd0);
                chk("stage_fw_rdy", 64'(rdys[s-1]),
                    64'(vt[i].exp_wr && (s >= int'(vt[i].lat))));
                chk("inflight", 64'(inf), vt[i].exp_wr ? 64'd1 : 64'd0);
                chk("inflight_other", 64'(inf_other), 64'd0);
                chk("lat_err", 64'(lat_err), 64'(vt[i].exp_lat_err));
            end
            @(negedge clk);
            chk("inflight_drained", 64'({inflight_even, inflight_odd}), 64'd0);
        end

        // Back-to-back even writes: counter saturates, addresses in order.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) chk("b2b_inflight", 64'(inflight_even), 64'((i < 7) ? i : 7));
            drive(1'b0, 1'b1, 7'(40 + i), 1'b1, 5'd3);
            push(1'b0, 7'(40 + i));
        end
        @(negedge clk);
        chk("b2b_inflight_hold", 64'(inflight_even), 64'd7);
        idle();
        repeat (10) @(negedge clk);

        // Flush depth 2 after five issues: the two youngest and the incoming die.
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 7'(60 + c), 1'b1, 5'd5);
            if (c == 5) begin
                flush = 1'b1;
                flush_depth = 3'd2;
            end
            if (c < 3) push(1'b0, 7'(60 + c));
        end
        @(negedge clk);
        chk("flush_wr", 64'(reg_wr_even), 64'b0111000);
        chk("flush_inflight", 64'(inflight_even), 64'd3);
        idle();
        repeat (10) @(negedge clk);

        // Same-register write on both pipes in the same cycle.
        @(negedge clk);
        chk("waw_before", 64'(waw_err), 64'd0);
        idle();
        drive(1'b0, 1'b1, 7'd12, 1'b1, 5'd4);
        drive(1'b1, 1'b1, 7'd12, 1'b1, 5'd4);
        push(1'b0, 7'd12);
        push(1'b1, 7'd12);
        @(negedge clk);
        idle();
        repeat (7) @(negedge clk);
        chk("waw_set", 64'(waw_err), 64'd1);
        chk("lat_err_sticky", 64'(lat_err), 64'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges with four writers in flight.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 7'(100 + i), 1'b1, 5'd4);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("pre_reset_inflight", 64'(inflight_even), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr", 64'(reg_wr_even), 64'd0);
        chk("async_dst", 64'(reg_dst_even), 64'd0);
        chk("async_misc", 64'({inflight_even, rf_we_even, lat_err, waw_err}), 64'd0);
        sb_e.delete();
        sb_o.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_flags", 64'({lat_err, waw_err, inflight_even}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
